alu_issue_stage: RTL and testbench

Buffered issue/execute stage wrapped around the team's combinational `ALU` block. It accepts operand/opcode requests over a valid/ready handshake and queues them in a small FIFO. It presents the FIFO head to the ALU's `A`/`B`/`AluOp` inputs and registers the ALU's `Result`/`Zero` into an output register with its own valid/ready handshake toward writeback. Together these decouple the operand-fetch stage from writeback backpressure.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_issue_fifo.sv | 83 ++++++++
 rtl/alu_issue_stage.sv | 81 ++++++++
 tb/tb_alu_issue_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and legality check.
// Used by the issue stage to flag unsupported operations.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD = 4'b0000;
  localparam alu_op_t OP_SUB = 4'b0010;
  localparam alu_op_t OP_AND = 4'b0100;
  localparam alu_op_t OP_OR  = 4'b0101;
  localparam alu_op_t OP_XOR = 4'b0110;
  localparam alu_op_t OP_NOR = 4'b0111;
  localparam alu_op_t OP_SGT = 4'b1010;

  function automatic logic op_is_legal(
    input alu_op_t op
  );
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SGT: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Circular operand queue feeding the ALU.
// Storage is intentionally left unreset; only pointers/count clear.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  output logic                     ready,
  input  logic [WIDTH-1:0]         push_a,
  input  logic [WIDTH-1:0]         push_b,
  input  alu_op_t                  push_op,
  input  logic [TAGW-1:0]          push_tag,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_a,
  output logic [WIDTH-1:0]         head_b,
  output alu_op_t                  head_op,
  output logic [TAGW-1:0]          head_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  alu_op_t          mem_op  [DEPTH];
  logic [TAGW-1:0]  mem_tag [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign ready   = (cnt != CW'(DEPTH));
  assign do_push = push && ready && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_a[wr_ptr]   <= push_a;
      mem_b[wr_ptr]   <= push_b;
      mem_op[wr_ptr]  <= push_op;
      mem_tag[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Empty queue presents a quiet ADD 0+0 to the ALU
  assign head_a   = empty ? '0 : mem_a[rd_ptr];
  assign head_b   = empty ? '0 : mem_b[rd_ptr];
  assign head_op  = empty ? OP_ADD : mem_op[rd_ptr];
  assign head_tag = empty ? '0 : mem_tag[rd_ptr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/execute stage: queues ALU requests and registers results.
// The ALU sits outside; head drives it, its result feeds our register.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [3:0]               in_op,
  input  logic [TAGW-1:0]          in_tag,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_illegal,
  output logic [TAGW-1:0]          out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  logic            pop;
  logic [TAGW-1:0] head_tag;

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .TAGW  (TAGW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (in_valid),
    .ready    (in_ready),
    .push_a   (in_a),
    .push_b   (in_b),
    .push_op  (in_op),
    .push_tag (in_tag),
    .pop      (pop),
    .head_a   (alu_a),
    .head_b   (alu_b),
    .head_op  (alu_op),
    .head_tag (head_tag),
    .count    (count)
  );

  assign pop = (count != '0) && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_zero    <= alu_zero;
      out_illegal <= !op_is_legal(alu_op);
      out_tag     <= head_tag;
    end else if (out_ready) begin
      // Consumed with nothing queued: drop valid, keep data
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + random bench for alu_issue_stage with a behavioural ALU
// and an in-order result scoreboard.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int TAGW  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [TAGW-1:0]  tag;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;
  logic [TAGW-1:0]  in_tag;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [TAGW-1:0]  out_tag;
  logic [CW-1:0]    count;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  alu_issue_stage #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .TAGW  (TAGW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .out_tag     (out_tag),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_alu(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1010: r = ($signed(a) > $signed(b)) ? 1 : 0;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stand-in for the external ALU
  always_comb begin
    alu_result = ref_alu(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == '0);
  end

  task automatic check(
    input string       name,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             name, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0010, 4'b0100, 4'b0101,
                      4'b0110, 4'b0111, 4'b1010};
  endfunction

  function automatic exp_t mk_exp(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       op,
    input logic [TAGW-1:0]  tag
  );
    exp_t e;
    e.result  = ref_alu(a, b, op);
    e.zero    = (e.result == '0);
    e.illegal = !legal(op);
    e.tag     = tag;
    return e;
  endfunction

  // Output monitor: transfer happens at the coming rising edge
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", 64'(out_tag), 64'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result",  64'(out_result),  64'(e.result));
        check("sb_zero",    64'(out_zero),    64'(e.zero));
        check("sb_illegal", 64'(out_illegal), 64'(e.illegal));
        check("sb_tag",     64'(out_tag),     64'(e.tag));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       op,
    input logic [TAGW-1:0]  tag
  );
    int guard;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("push_timeout", 64'(in_ready), 64'd1);
    else sb.push_back(mk_exp(a, b, op, tag));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int guard;
    out_ready = 1'b1;
    guard     = 0;
    while ((out_valid || count != 0) && guard < 50) begin
      tick();
      guard++;
    end
    check("drain_done", 64'(out_valid || count != 0), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("empty_alu_op",  64'(alu_op),    64'd0);
    check("empty_alu_a",   64'(alu_a),     64'd0);

    // ADD 5+7
    push(5, 7, OP_ADD, 3);
    check("add_count_q", 64'(count), 64'd1);
    check("add_alu_a", 64'(alu_a), 64'd5);
    tick();
    check("add_valid",  64'(out_valid),  64'd1);
    check("add_result", 64'(out_result), 64'd12);
    check("add_zero",   64'(out_zero),   64'd0);
    check("add_tag",    64'(out_tag),    64'd3);

    // SUB 9-9
    push(9, 9, OP_SUB, 1);
    tick();
    check("sub_result",  64'(out_result),  64'd0);
    check("sub_zero",    64'(out_zero),    64'd1);
    check("sub_illegal", 64'(out_illegal), 64'd0);
    tick();
    tick();
    check("idle_valid", 64'(out_valid), 64'd0);

    // Fill with backpressure
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = WIDTH'(i * 3);
      in_b     = WIDTH'(i + 1);
      in_op    = OP_ADD;
      in_tag   = TAGW'(i);
      if (in_ready) begin
        acc++;
        sb.push_back(mk_exp(in_a, in_b, in_op, in_tag));
      end
      tick();
    end
    in_valid = 1'b0;
    check("fill_accepted", 64'(acc),       64'd5);
    check("fill_in_ready", 64'(in_ready),  64'd0);
    check("fill_count",    64'(count),     64'd4);
    check("fill_valid",    64'(out_valid), 64'd1);
    check("fill_head_a",   64'(alu_a),     64'd3);
    tick();
    check("stall_tag", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("rel_tag",   64'(out_tag),   64'(k));
      check("rel_valid", 64'(out_valid), 64'd1);
      check("rel_count", 64'(count),     64'(4 - k));
      tick();
    end
    check("rel_empty", 64'(count), 64'd0);
    check("rel_drained", 64'(out_valid), 64'd0);

    // Illegal opcode
    push(1, 1, 4'b1111, 9);
    tick();
    check("ill_result",  64'(out_result),  64'd0);
    check("ill_zero",    64'(out_zero),    64'd1);
    check("ill_illegal", 64'(out_illegal), 64'd1);
    check("ill_tag",     64'(out_tag),     64'd9);
    drain();

    // Random traffic
    for (int c = 0; c < 60; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = $urandom();
      in_b      = ($urandom_range(0, 3) == 0) ? in_a : $urandom();
      in_op     = 4'($urandom_range(0, 15));
      in_tag    = TAGW'($urandom());
      if (in_valid && in_ready)
        sb.push_back(mk_exp(in_a, in_b, in_op, in_tag));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Flush with a concurrent push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(WIDTH'(i), 1, OP_OR, TAGW'(i + 4));
    check("pre_flush_count", 64'(count),     64'd3);
    check("pre_flush_valid", 64'(out_valid), 64'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h55;
    in_op    = OP_ADD;
    in_tag   = 4'hf;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_count", 64'(count),     64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    check("flush_absent", 64'(out_valid), 64'd0);
    check("flush_absent_cnt", 64'(count), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(3, 4, OP_XOR, 2);
    push(3, 4, OP_AND, 6);
    push(3, 4, OP_SGT, 7);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_valid",   64'(out_valid),   64'd0);
    check("arst_result",  64'(out_result),  64'd0);
    check("arst_zero",    64'(out_zero),    64'd0);
    check("arst_illegal", 64'(out_illegal), 64'd0);
    check("arst_tag",     64'(out_tag),     64'd0);
    check("arst_count",   64'(count),       64'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    push(2, 2, OP_ADD, 5);
    tick();
    check("post_rst_result", 64'(out_result), 64'd4);
    check("post_rst_tag",    64'(out_tag),    64'd5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
